// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures the i_div_clk period in i_clk cycles, locks after
// LOCK_COUNT consecutive periods of DIV, and flags bad periods and timeouts.
//
// state   | meaning
// SEARCH  | waiting for the first rise; no period checking
// ACQUIRE | counting consecutive good periods towards lock
// LOCKED  | period verified at DIV; any deviation drops lock

module clk_div_monitor #(
    parameter int DIV        = 6,
    parameter int LOCK_COUNT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_div_clk,
    output logic       o_tick,
    output logic [3:0] o_period,
    output logic       o_locked,
    output logic       o_err,
    output logic [7:0] o_err_cnt
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam logic [3:0] DIV_L  = 4'(DIV);
    localparam logic [3:0] LOCK_L = 4'(LOCK_COUNT);

    state_t     state;
    state_t     state_nxt;
    logic       prev;
    logic       rise;
    logic       timeout;
    logic [3:0] cnt;
    logic [3:0] meas;
    logic [3:0] good;
    logic [3:0] good_nxt;
    logic       period_ld;
    logic       err_nxt;
    logic       locked_nxt;

    assign rise    = i_div_clk & ~prev;
    assign meas    = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;
    // A rise in the same cycle wins; it is judged as a 15-cycle period instead.
    assign timeout = (state != SEARCH) && !rise && (cnt == 4'd15);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= SEARCH;
            prev      <= 1'b0;
            cnt       <= 4'd0;
            good      <= 4'd0;
            o_tick    <= 1'b0;
            o_period  <= 4'd0;
            o_locked  <= 1'b0;
            o_err     <= 1'b0;
            o_err_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            prev     <= i_div_clk;
            good     <= good_nxt;
            o_tick   <= rise;
            o_locked <= locked_nxt;
            o_err    <= err_nxt;
            if (rise)
                cnt <= 4'd0;
            else if (cnt != 4'd15)
                cnt <= cnt + 4'd1;
            if (period_ld)
                o_period <= meas;
            if (err_nxt && (o_err_cnt != 8'hFF))
                o_err_cnt <= o_err_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        case (state)
            SEARCH: begin
                if (rise) begin
                    state_nxt = ACQUIRE;
                    good_nxt  = 4'd0;
                end
            end
            ACQUIRE: begin
                if (rise) begin
                    if (meas == DIV_L) begin
                        good_nxt = good + 4'd1;
                        if (good + 4'd1 == LOCK_L)
                            state_nxt = LOCKED;
                    end else begin
                        good_nxt = 4'd0;
                    end
                end else if (timeout) begin
                    state_nxt = SEARCH;
                    good_nxt  = 4'd0;
                end
            end
            LOCKED: begin
                if (rise) begin
                    if (meas != DIV_L) begin
                        state_nxt = ACQUIRE;
                        good_nxt  = 4'd0;
                    end
                end else if (timeout) begin
                    state_nxt = SEARCH;
                    good_nxt  = 4'd0;
                end
            end
            default: begin
                state_nxt = SEARCH;
                good_nxt  = 4'd0;
            end
        endcase
    end

    always_comb begin
        period_ld  = rise && (state != SEARCH);
        err_nxt    = (period_ld && (meas != DIV_L)) || timeout;
        locked_nxt = (state_nxt == LOCKED);
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor (DIV=6, LOCK_COUNT=4): stimulus queues the
// expected output snapshot per rise/timeout, a monitor pops it on o_tick or o_err.

module tb_clk_div_monitor;

    typedef struct packed {
        logic       tick;
        logic       err;
        logic [3:0] period;
        logic       locked;
        logic [7:0] err_cnt;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       div_clk;
    logic       tick;
    logic [3:0] period;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    ev_t exp_q[$];

    clk_div_monitor #(.DIV(6), .LOCK_COUNT(4)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_div_clk (div_clk),
        .o_tick    (tick),
        .o_period  (period),
        .o_locked  (locked),
        .o_err     (err),
        .o_err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_tick"},    int'(tick),    0);
        check({name, "_period"},  int'(period),  0);
        check({name, "_locked"},  int'(locked),  0);
        check({name, "_err"},     int'(err),     0);
        check({name, "_err_cnt"}, int'(err_cnt), 0);
    endtask

    // Holds div_clk low for gap-1 cycles then raises it, so this rise lands gap
    // cycles after the previous one; the expected response is queued alongside.
    task automatic rise_after(input int gap, input logic [3:0] p, input logic l,
                              input logic e, input logic [7:0] ec);
        repeat (gap - 1) begin
            @(negedge clk);
            div_clk = 1'b0;
        end
        @(negedge clk);
        div_clk = 1'b1;
        exp_q.push_back('{tick: 1'b1, err: e, period: p, locked: l, err_cnt: ec});
    endtask

    // Monitor: every output event must match the oldest queued expectation.
    initial begin
        ev_t got;
        ev_t want;
        forever begin
            @(posedge clk);
            #1;
            if (tick || err) begin
                got = '{tick: tick, err: err, period: period, locked: locked, err_cnt: err_cnt};
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got tick=%0b err=%0b period=%0d locked=%0b err_cnt=%0d, expected no event at %0t",
                             got.tick, got.err, got.period, got.locked, got.err_cnt, $time);
                end else begin
                    want = exp_q.pop_front();
                    if (got != want) begin
                        n_fail++;
                        $display("FAIL event: got tick=%0b err=%0b period=%0d locked=%0b err_cnt=%0d, expected tick=%0b err=%0b period=%0d locked=%0b err_cnt=%0d at %0t",
                                 got.tick, got.err, got.period, got.locked, got.err_cnt,
                                 want.tick, want.err, want.period, want.locked, want.err_cnt, $time);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        div_clk = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Nominal lock: first rise only enters ACQUIRE, lock after the 5th rise.
        rise_after(3, 4'd0, 1'b0, 1'b0, 8'd0);
        repeat (3) rise_after(6, 4'd6, 1'b0, 1'b0, 8'd0);
        rise_after(6, 4'd6, 1'b1, 1'b0, 8'd0);
        rise_after(6, 4'd6, 1'b1, 1'b0, 8'd0);

        // Loss of lock on a 7-cycle period, then relock after four good periods.
        rise_after(7, 4'd7, 1'b0, 1'b1, 8'd1);
        repeat (3) rise_after(6, 4'd6, 1'b0, 1'b0, 8'd1);
        rise_after(6, 4'd6, 1'b1, 1'b0, 8'd1);

        // Timeout: last rise sampled at edge P0, error appears at P0+16.
        exp_q.push_back('{tick: 1'b0, err: 1'b1, period: 4'd6, locked: 1'b0, err_cnt: 8'd2});
        @(posedge clk);
        @(negedge clk);
        div_clk = 1'b0;
        repeat (14) @(posedge clk);
        @(posedge clk);
        #1;
        check("timeout_early", int'(err), 0);
        check("locked_before_timeout", int'(locked), 1);
        @(posedge clk);
        #1;
        check("timeout_at_16", int'(err), 1);
        repeat (30) @(negedge clk);

        // Boundary: from SEARCH, then a rise exactly at cnt=15 is one bad period.
        rise_after(4, 4'd6, 1'b0, 1'b0, 8'd2);
        rise_after(16, 4'd15, 1'b0, 1'b1, 8'd3);
        repeat (3) rise_after(6, 4'd6, 1'b0, 1'b0, 8'd3);
        rise_after(6, 4'd6, 1'b1, 1'b0, 8'd3);

        // One-cycle reset while locked clears everything; relock needs five rises.
        @(negedge clk);
        rst_n   = 1'b0;
        div_clk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("mid_reset");
        rise_after(6, 4'd0, 1'b0, 1'b0, 8'd0);
        repeat (3) rise_after(6, 4'd6, 1'b0, 1'b0, 8'd0);
        rise_after(6, 4'd6, 1'b1, 1'b0, 8'd0);

        // Saturation: 300 bad periods, then a timeout that must not wrap the count.
        for (int i = 1; i <= 300; i++)
            rise_after(7, 4'd7, 1'b0, 1'b1, (i > 255) ? 8'd255 : 8'(i));
        exp_q.push_back('{tick: 1'b0, err: 1'b1, period: 4'd7, locked: 1'b0, err_cnt: 8'd255});
        @(negedge clk);
        div_clk = 1'b0;
        repeat (25) @(negedge clk);
        check("err_cnt_saturated", int'(err_cnt), 255);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
